// File: rtl/ram2_ctrl.sv
// ram2_ctrl: valid/ready front end for the ram2 single-port RAM. It owns ena/wena/addr and the shared data bus.
// Optional hardware clear sequence compiled in when RAM2_CTRL_CLEAR_EN is defined.
module ram2_ctrl #(
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              clr_start,
    output logic              clr_done,
    output logic              busy,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1
`ifdef RAM2_CTRL_CLEAR_EN
      , S_CLEAR  = 2'd2
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ram_ena;
    logic              r_ram_wena;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_clr_done;
    logic              w_ena_nxt;
    logic              w_wena_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic              w_clr_done_nxt;
    logic              w_drive;

`ifdef RAM2_CTRL_CLEAR_EN
    localparam logic [ADDR_W-1:0] W_CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] W_CNT_MAX = {ADDR_W{1'b1}};
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    // A pending clear blocks the handshake in the same cycle it is requested.
    assign req_ready = (r_state == S_IDLE) & ~clr_start;
`else
    logic w_unused_clr_start;
    assign w_unused_clr_start = clr_start;
    assign req_ready          = (r_state == S_IDLE);
`endif

    // Next-state and next-output decode; the RAM-facing lines are registered from these.
    always_comb begin
        w_state_nxt     = r_state;
        w_ena_nxt       = 1'b0;
        w_wena_nxt      = 1'b0;
        w_addr_nxt      = r_ram_addr;
        w_wdata_nxt     = r_wdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_clr_done_nxt  = 1'b0;
`ifdef RAM2_CTRL_CLEAR_EN
        w_cnt_nxt       = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef RAM2_CTRL_CLEAR_EN
                if (clr_start) begin
                    w_state_nxt = S_CLEAR;
                    w_ena_nxt   = 1'b1;
                    w_wena_nxt  = 1'b1;
                    w_addr_nxt  = '0;
                    w_wdata_nxt = CLR_VALUE;
                    w_cnt_nxt   = '0;
                end else
`endif
                if (req_valid) begin
                    w_state_nxt = S_ACCESS;
                    w_ena_nxt   = 1'b1;
                    w_wena_nxt  = req_we;
                    w_addr_nxt  = req_addr;
                    w_wdata_nxt = req_wdata;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_IDLE;
                if (r_ram_wena) begin
                    w_rsp_valid_nxt = 1'b0;
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = ram_data;
                end
            end
`ifdef RAM2_CTRL_CLEAR_EN
            S_CLEAR: begin
                if (r_cnt == W_CNT_MAX) begin
                    w_state_nxt    = S_IDLE;
                    w_clr_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + W_CNT_ONE;
                    w_ena_nxt   = 1'b1;
                    w_wena_nxt  = 1'b1;
                    w_addr_nxt  = r_cnt + W_CNT_ONE;
                    w_wdata_nxt = CLR_VALUE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ram_ena   <= 1'b0;
            r_ram_wena  <= 1'b0;
            r_ram_addr  <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_clr_done  <= 1'b0;
`ifdef RAM2_CTRL_CLEAR_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ram_ena   <= w_ena_nxt;
            r_ram_wena  <= w_wena_nxt;
            r_ram_addr  <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_clr_done  <= w_clr_done_nxt;
`ifdef RAM2_CTRL_CLEAR_EN
            r_cnt       <= w_cnt_nxt;
`endif
        end
    end

    // Bus drive uses the same registers as ena/wena, so it never overlaps a RAM read.
    assign w_drive   = r_ram_ena & r_ram_wena;
    assign ram_data  = w_drive ? r_wdata : {DATA_W{1'bz}};
    assign ram_ena   = r_ram_ena;
    assign ram_wena  = r_ram_wena;
    assign ram_addr  = r_ram_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign clr_done  = r_clr_done;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/ram2_ctrl.md
# ram2_ctrl

Sequencing controller that sits directly upstream of the `ram2` 32×32 single-port RAM and owns its `ena`/`wena`/`addr` lines and the bidirectional `data_io` bus. It turns a simple valid/ready request interface into correctly timed RAM write and read cycles. It tristates the shared bus whenever the RAM may drive it and returns read data on a one-cycle response pulse. It also provides a hardware clear sequence that fills every RAM word with a constant.

## Interface
Parameters:
- `ADDR_W`, default 5: RAM address width; depth = 2^ADDR_W.
- `DATA_W`, default 32: RAM word width.
- `CLR_VALUE`, default 0: word written to every address by the clear sequence.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept a request this cycle.
- `req_we`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDR_W: target address.
- `req_wdata`  in  DATA_W: write data.
- `rsp_valid`  out  1: one-cycle pulse; read data valid.
- `rsp_rdata`  out  DATA_W: captured read data.
- `clr_start`  in  1: start the clear sequence.
- `clr_done`  out  1: one-cycle pulse when clear completes.
- `busy`  out  1: controller not in IDLE.
- `ram_ena`  out  1: RAM enable.
- `ram_wena`  out  1: RAM write enable.
- `ram_addr`  out  ADDR_W: RAM address.
- `ram_data`  inout  DATA_W: RAM data bus; connects to `data_io`.

## Operation
RAM contract:
- Writes `ram_data` at the rising edge when `ram_ena=1` and `ram_wena=1`.
- Drives `ram_data` combinationally from `ram_addr` when `ram_ena=1` and `ram_wena=0`.

States: IDLE, ACCESS, CLEAR.
- **IDLE:** `req_ready=1`, `busy=0`, `ram_ena=0`.
  - `clr_start=1` → CLEAR, and `clr_start` has priority. `req_valid` asserted in the same cycle is not accepted, because `req_ready` is deasserted combinationally when `clr_start=1`.
  - Otherwise `req_valid=1` → ACCESS. `req_we`, `req_addr` and `req_wdata` are latched at that edge.
- **ACCESS:** lasts exactly one cycle.
  - `ram_ena=1`, `ram_wena=latched we`, `ram_addr=latched addr`.
  - Write: the controller drives the latched wdata onto `ram_data`.
  - Read: `ram_data` is high-Z and is sampled into `rsp_rdata` at the closing edge.
  - Returns to IDLE.
- **CLEAR:**
  - A counter runs from 0 to 2^ADDR_W−1.
  - Each cycle: `ram_ena=1`, `ram_wena=1`, `ram_addr=counter`, and `ram_data` is driven with CLR_VALUE.
  - After the last address, the next edge returns to IDLE and pulses `clr_done`.
  - `req_valid` and `clr_start` are ignored in this state.
- Bus drive enable = `ram_ena & ram_wena`, decoded from the same registers as those outputs. `ram_data` is high-Z in every other case, so there is no bus contention.
- `rsp_rdata` holds its value until the next read completes. Writes never change it.
- There is no backpressure on the response side.

## Timing
- Reset values: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `clr_done=0`, `busy=0`, `ram_ena=0`, `ram_wena=0`, `ram_addr=0`, `ram_data` high-Z, clear counter 0.
- Handshake edge E0 (`req_valid & req_ready`): ACCESS is active in the cycle after E0.
  - Write: the RAM commits at E1.
  - Read: `rsp_rdata` is updated at E1, and `rsp_valid=1` for the cycle after E1.
- Throughput is one access per 2 cycles. `req_ready` is low during ACCESS.
- Clear takes 2^ADDR_W cycles (32 by default). `clr_done` is high for the one cycle after the final write edge. `busy` is high from the edge after `clr_start` until `clr_done`.
- The clear counter wraps at its maximum. CLEAR exits on counter == 2^ADDR_W−1, not on wrap.
- `rst` mid-ACCESS or mid-CLEAR:
  - At the next edge, return to reset values and release the bus.
  - No `rsp_valid` and no `clr_done` are emitted.
  - RAM words already written are retained.
- `rst` overrides every other input in the same cycle.

## Configuration
- `RAM2_CTRL_CLEAR_EN` defined: the CLEAR state, counter, `clr_start` and `clr_done` behave as above.
- `RAM2_CTRL_CLEAR_EN` not defined:
  - No CLEAR state or counter logic is compiled.
  - `clr_start` is ignored; `clr_done` is tied 0.
  - `busy` equals `~req_ready`.
  - The request path is unchanged.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `req_valid=1`. Outputs must equal their reset values, `ram_data` must be Z, and no request is accepted.
- **Write then read:** write 32'hAB10_4588 to addr 10, then read addr 10. `rsp_valid` pulses 1 cycle, exactly 2 cycles after the read handshake edge, with `rsp_rdata`=32'hAB10_4588. `ram_data` is Z during the read ACCESS.
- **Back-to-back:** keep `req_valid=1` with writes to addrs 1, 2 and 3 (data 32'h0000_0010, 32'h7896_1255, 32'hFFFF_FFFF). `req_ready` toggles 1,0,1,0. Reading each address back returns its data.
- **Clear:**
  - Fill addr 0 and addr 31 with 32'hFFFF_FFFF, then pulse `clr_start`.
  - `busy` must stay high 32 cycles and `clr_done` pulse once.
  - Reads of addrs 0, 17 and 31 return CLR_VALUE (0).
- **Simultaneous start:** assert `clr_start` and `req_valid` (write addr 5 = 32'h1234_5678) in the same IDLE cycle. The clear wins and the request is not accepted. After `clr_done` the request is accepted, and addr 5 reads 32'h1234_5678.
- **Reset mid-clear:** assert `rst` at clear cycle 10. There is no `clr_done`. Addrs 0–9 read 0, and addr 20 keeps its prior value 32'hDEAD_BEEF.
